pll_md_ctrl: RTL and testbench



---
 rtl/pll_md_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_pll_md_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_md_ctrl.sv
// pll_md_ctrl: host-facing controller that programs PLL divider registers over
// the MD bus (address-load + write/read slots), waits for the PLL to relock
// after a write, and returns a single-cycle response per request.
module pll_md_ctrl #(
    parameter int         NUM_CH      = 2,
    parameter logic [7:0] ADDR_BASE   = 8'h10,
    parameter int         LOCK_STABLE = 16,
    parameter int         LOCK_TO     = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [2:0] req_ch,
    input  logic [7:0] req_div,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       lock,
    output logic       lock_lost,
    output logic       mdclk,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    input  logic [7:0] mdrdo
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TO + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TO_MAX     = TW'(LOCK_TO);
    localparam logic [3:0]    NUM_CH_W   = 4'(NUM_CH);

    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_ADDR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADDR,
        OP,
        CAPT,
        WAIT_LOCK,
        RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic          r_mdclk;
    logic [1:0]    r_mdopc;
    logic [7:0]    r_mdwdi;
    logic          r_rd;
    logic [2:0]    r_ch;
    logic [7:0]    r_div;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_err;
    logic          r_lock_lost;
    logic [SW-1:0] r_stable;
    logic [TW-1:0] r_total;
    logic [7:0]    r_shadow [8];

    logic          w_slot;
    logic          w_bad;
    logic [7:0]    w_addr;
    logic [7:0]    w_rd_val;
    logic [SW-1:0] w_stable_nxt;
    logic [TW-1:0] w_total_nxt;
    logic          w_stable_hit;
    logic          w_total_hit;

    // Slot boundary: mdclk is currently high, so this edge drives it low and
    // begins a new two-cycle MD slot; all MD-bus phase changes happen here.
    always_comb begin
        w_slot   = r_mdclk;
        w_bad    = ({1'b0, r_ch} >= NUM_CH_W) || (!r_rd && (r_div == '0));
        w_addr   = ADDR_BASE + {5'b0, r_ch};
        w_rd_val = (mdrdo != '0) ? mdrdo : r_shadow[r_ch];
    end

    // Relock counters: consecutive lock-high cycles and total cycles waited.
    always_comb begin
        w_stable_nxt = lock ? (r_stable + SW'(1)) : '0;
        w_total_nxt  = r_total + TW'(1);
        w_stable_hit = (w_stable_nxt >= STABLE_MAX);
        w_total_hit  = (w_total_nxt >= TO_MAX);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and handshake outputs; MD-bus states advance only on
    // slot boundaries so each ADDR/OP phase occupies exactly one slot.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (w_bad) begin
                    w_state_nxt = RESP;
                end else if (w_slot) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (w_slot) begin
                    w_state_nxt = OP;
                end
            end
            OP: begin
                if (w_slot) begin
                    w_state_nxt = r_rd ? CAPT : WAIT_LOCK;
                end
            end
            CAPT: begin
                if (w_slot) begin
                    w_state_nxt = RESP;
                end
            end
            WAIT_LOCK: begin
                if (w_stable_hit || w_total_hit) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // MD clock divider and slot-aligned opcode/data drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdclk <= 1'b0;
            r_mdopc <= OPC_NOP;
            r_mdwdi <= '0;
        end else begin
            r_mdclk <= ~r_mdclk;
            if (w_slot) begin
                case (w_state_nxt)
                    ADDR: begin
                        r_mdopc <= OPC_ADDR;
                        r_mdwdi <= w_addr;
                    end
                    OP: begin
                        r_mdopc <= r_rd ? OPC_RD : OPC_WR;
                        r_mdwdi <= r_rd ? 8'h00 : r_div;
                    end
                    default: begin
                        r_mdopc <= OPC_NOP;
                        r_mdwdi <= '0;
                    end
                endcase
            end
        end
    end

    // Request latch, shadow registers, relock counters, response and lock_lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd        <= 1'b0;
            r_ch        <= '0;
            r_div       <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_lock_lost <= 1'b0;
            r_stable    <= '0;
            r_total     <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_stable <= '0;
            r_total  <= '0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_rd  <= req_rd;
                        r_ch  <= req_ch;
                        r_div <= req_div;
                    end
                    if (!lock) begin
                        r_lock_lost <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_bad) begin
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                    end
                end
                ADDR: begin
                    if (w_slot && !r_rd) begin
                        r_shadow[r_ch] <= r_div;
                    end
                end
                CAPT: begin
                    if (w_slot) begin
                        r_rsp_data <= w_rd_val;
                        r_rsp_err  <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    r_stable <= w_stable_nxt;
                    r_total  <= w_total_nxt;
                    if (w_stable_hit || w_total_hit) begin
                        r_rsp_err  <= !w_stable_hit;
                        r_rsp_data <= r_div;
                    end
                end
                RESP: begin
                    if (!r_rd && !r_rsp_err) begin
                        r_lock_lost <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mdclk     = r_mdclk;
    assign mdopc     = r_mdopc;
    assign mdwdi     = r_mdwdi;
    assign mdainc    = 1'b0;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_pll_md_ctrl.sv
// tb_pll_md_ctrl: directed bench for pll_md_ctrl with hand-computed
// expectations for MD slots, response latency, data and flags.
module tb_pll_md_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [2:0] req_ch;
    logic [7:0] req_div;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       lock;
    logic       lock_lost;
    logic       mdclk;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pll_md_ctrl #(
        .NUM_CH(2),
        .ADDR_BASE(8'h10),
        .LOCK_STABLE(16),
        .LOCK_TO(4096)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rd(req_rd),
        .req_ch(req_ch),
        .req_div(req_div),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .lock(lock),
        .lock_lost(lock_lost),
        .mdclk(mdclk),
        .mdopc(mdopc),
        .mdainc(mdainc),
        .mdwdi(mdwdi),
        .mdrdo(mdrdo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE; returns at the negedge where the DUT is in CHECK.
    task automatic send(input logic rd, input logic [2:0] ch, input logic [7:0] div);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_rd    = rd;
        req_ch    = ch;
        req_div   = div;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    endtask

    task automatic wait_opc();
        int unsigned n;
        n = 0;
        while (mdopc == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("opc_start", {31'b0, (mdopc != 2'b00)}, 32'd1);
    endtask

    // Check one two-cycle MD slot starting at the current negedge.
    task automatic slot(input string tag, input logic [1:0] opc, input logic [7:0] wdi,
                        input bit chk_wdi);
        chk({tag, "_opc_a"}, {30'b0, mdopc}, {30'b0, opc});
        chk({tag, "_mdclk_a"}, {31'b0, mdclk}, 32'd0);
        if (chk_wdi) chk({tag, "_wdi_a"}, {24'b0, mdwdi}, {24'b0, wdi});
        @(negedge clk);
        chk({tag, "_opc_b"}, {30'b0, mdopc}, {30'b0, opc});
        chk({tag, "_mdclk_b"}, {31'b0, mdclk}, 32'd1);
        if (chk_wdi) chk({tag, "_wdi_b"}, {24'b0, mdwdi}, {24'b0, wdi});
        @(negedge clk);
    endtask

    task automatic wait_rsp(output int unsigned n, input int unsigned lim);
        n = 0;
        while (!rsp_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic rsp_end(input string tag);
        @(negedge clk);
        chk({tag, "_one_cycle"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit          seen;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rd    = 1'b0;
        req_ch    = '0;
        req_div   = '0;
        lock      = 1'b1;
        mdrdo     = '0;
        repeat (3) @(negedge clk);

        chk("rst_mdopc", {30'b0, mdopc}, 32'd0);
        chk("rst_mdwdi", {24'b0, mdwdi}, 32'd0);
        chk("rst_mdclk", {31'b0, mdclk}, 32'd0);
        chk("rst_mdainc", {31'b0, mdainc}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_rsp_data", {24'b0, rsp_data}, 32'd0);
        chk("rst_lock_lost", {31'b0, lock_lost}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("post_rst_mdclk", {31'b0, mdclk}, 32'd1);

        // Write ch1 div 20, lock high
        send(1'b0, 3'd1, 8'd20);
        wait_opc();
        slot("w1_addr", 2'b11, 8'h11, 1'b1);
        slot("w1_op", 2'b01, 8'd20, 1'b1);
        chk("w1_opc_after", {30'b0, mdopc}, 32'd0);
        chk("w1_wdi_after", {24'b0, mdwdi}, 32'd0);
        wait_rsp(n, 40);
        chk("w1_latency", n, 32'd16);
        chk("w1_err", {31'b0, rsp_err}, 32'd0);
        chk("w1_data", {24'b0, rsp_data}, 32'd20);
        rsp_end("w1");

        // Read ch0, MD returns 10
        mdrdo = 8'd10;
        send(1'b1, 3'd0, 8'd0);
        wait_opc();
        slot("r0_addr", 2'b11, 8'h10, 1'b1);
        slot("r0_op", 2'b10, 8'h00, 1'b0);
        chk("r0_opc_after", {30'b0, mdopc}, 32'd0);
        wait_rsp(n, 10);
        chk("r0_latency", n, 32'd2);
        chk("r0_err", {31'b0, rsp_err}, 32'd0);
        chk("r0_data", {24'b0, rsp_data}, 32'd10);
        rsp_end("r0");

        // Read ch1, MD returns 0 -> shadow value 20
        mdrdo = 8'd0;
        send(1'b1, 3'd1, 8'd0);
        wait_opc();
        slot("r1_addr", 2'b11, 8'h11, 1'b1);
        slot("r1_op", 2'b10, 8'h00, 1'b0);
        wait_rsp(n, 10);
        chk("r1_latency", n, 32'd2);
        chk("r1_shadow_data", {24'b0, rsp_data}, 32'd20);
        rsp_end("r1");

        // Write to out-of-range channel 7
        send(1'b0, 3'd7, 8'h33);
        n = 0;
        seen = 1'b0;
        while (!rsp_valid && n < 6) begin
            @(negedge clk);
            n++;
            if (mdopc != 2'b00) seen = 1'b1;
        end
        chk("badch_within3", {31'b0, (n >= 1 && n <= 3)}, 32'd1);
        chk("badch_no_md", {31'b0, seen}, 32'd0);
        chk("badch_err", {31'b0, rsp_err}, 32'd1);
        chk("badch_data", {24'b0, rsp_data}, 32'd0);
        rsp_end("badch");

        // Write with divider 0
        send(1'b0, 3'd0, 8'd0);
        wait_rsp(n, 6);
        chk("div0_within3", {31'b0, (n >= 1 && n <= 3)}, 32'd1);
        chk("div0_err", {31'b0, rsp_err}, 32'd1);
        chk("div0_data", {24'b0, rsp_data}, 32'd0);
        rsp_end("div0");

        // Lock low in IDLE sets lock_lost; write ch0 div 5 times out
        lock = 1'b0;
        @(negedge clk);
        chk("lock_lost_set", {31'b0, lock_lost}, 32'd1);
        send(1'b0, 3'd0, 8'd5);
        wait_opc();
        slot("to_addr", 2'b11, 8'h10, 1'b1);
        slot("to_op", 2'b01, 8'd5, 1'b1);
        wait_rsp(n, 5000);
        chk("to_latency", n, 32'd4096);
        chk("to_err", {31'b0, rsp_err}, 32'd1);
        chk("to_data", {24'b0, rsp_data}, 32'd5);
        rsp_end("to");
        chk("to_lock_lost_kept", {31'b0, lock_lost}, 32'd1);

        // Read ch0 with MD returning 0 -> shadow 5; lock_lost still sticky
        lock = 1'b1;
        send(1'b1, 3'd0, 8'd0);
        wait_opc();
        slot("r0s_addr", 2'b11, 8'h10, 1'b1);
        slot("r0s_op", 2'b10, 8'h00, 1'b0);
        wait_rsp(n, 10);
        chk("r0s_data", {24'b0, rsp_data}, 32'd5);
        rsp_end("r0s");
        chk("rd_lock_lost_kept", {31'b0, lock_lost}, 32'd1);

        // Write ch1 div 33, lock drops for one cycle at WAIT_LOCK cycle 10
        send(1'b0, 3'd1, 8'd33);
        wait_opc();
        slot("gl_addr", 2'b11, 8'h11, 1'b1);
        slot("gl_op", 2'b01, 8'd33, 1'b1);
        n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 9) lock = 1'b0;
            else if (n == 10) lock = 1'b1;
        end
        chk("gl_latency", n, 32'd26);
        chk("gl_err", {31'b0, rsp_err}, 32'd0);
        chk("gl_data", {24'b0, rsp_data}, 32'd33);
        rsp_end("gl");
        chk("gl_lock_lost_clr", {31'b0, lock_lost}, 32'd0);

        // Reset during the OP slot of a write
        send(1'b0, 3'd0, 8'd9);
        wait_opc();
        slot("rs_addr", 2'b11, 8'h10, 1'b1);
        chk("rs_op_before", {30'b0, mdopc}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_mdopc_async", {30'b0, mdopc}, 32'd0);
        chk("rs_mdwdi_async", {24'b0, mdwdi}, 32'd0);
        chk("rs_mdclk_async", {31'b0, mdclk}, 32'd0);
        chk("rs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rs_no_rsp", {31'b0, seen}, 32'd0);

        // Next request completes normally
        send(1'b0, 3'd1, 8'd7);
        wait_opc();
        slot("nx_addr", 2'b11, 8'h11, 1'b1);
        slot("nx_op", 2'b01, 8'd7, 1'b1);
        wait_rsp(n, 40);
        chk("nx_latency", n, 32'd16);
        chk("nx_err", {31'b0, rsp_err}, 32'd0);
        chk("nx_data", {24'b0, rsp_data}, 32'd7);
        rsp_end("nx");

        // Shadow of ch0 was cleared by reset
        mdrdo = 8'd0;
        send(1'b1, 3'd0, 8'd0);
        wait_opc();
        slot("sh_addr", 2'b11, 8'h10, 1'b1);
        slot("sh_op", 2'b10, 8'h00, 1'b0);
        wait_rsp(n, 10);
        chk("sh_data", {24'b0, rsp_data}, 32'd0);
        rsp_end("sh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
